// File: rtl/lc3_reg_file_if.sv
// Bundle of the LC-3 register-file datapath, condition-code and dump handshake signals.
// The datapath/debug side drives through master; the register file attaches as slave.
interface lc3_reg_file_if #(
  parameter int WIDTH = 16
);
  logic             LD_REG;
  logic [2:0]       DR;
  logic [2:0]       SR1;
  logic [2:0]       SR2;
  logic [WIDTH-1:0] BUS_in;
  logic             LD_CC;
  logic [WIDTH-1:0] SR1_OUT;
  logic [WIDTH-1:0] SR2_OUT;
  logic             N;
  logic             Z;
  logic             P;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [2:0]       dump_idx;
  logic [WIDTH-1:0] dump_data;
  logic             dump_busy;

  modport master (
    output LD_REG, DR, SR1, SR2, BUS_in, LD_CC, dump_start, dump_ready,
    input  SR1_OUT, SR2_OUT, N, Z, P, dump_valid, dump_idx, dump_data, dump_busy
  );

  modport slave (
    input  LD_REG, DR, SR1, SR2, BUS_in, LD_CC, dump_start, dump_ready,
    output SR1_OUT, SR2_OUT, N, Z, P, dump_valid, dump_idx, dump_data, dump_busy
  );
endinterface

// File: rtl/lc3_reg_file.sv
// LC-3 register file R0-R7 with NZP codes and a valid/ready register dump engine.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module lc3_reg_file #(
  parameter int WIDTH = 16
) (
  input logic           Clk,
  input logic           Reset,
  lc3_reg_file_if.slave rf
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} dump_state_t;

  dump_state_t      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] regs_q [8];
  logic             n_q, z_q, p_q;

  // A capture landing on the register being written must see the new value.
  function automatic logic [WIDTH-1:0] capture_value(
    input logic [2:0]       idx,
    input logic             ld,
    input logic [2:0]       dr,
    input logic [WIDTH-1:0] bus,
    input logic [WIDTH-1:0] stored
  );
    return (ld && (dr == idx)) ? bus : stored;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= {WIDTH{1'b0}};
    end else if (rf.LD_REG) begin
      regs_q[rf.DR] <= rf.BUS_in;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      n_q <= 1'b0;
      z_q <= 1'b1;
      p_q <= 1'b0;
    end else if (rf.LD_CC) begin
      n_q <= rf.BUS_in[WIDTH-1];
      z_q <= (rf.BUS_in == {WIDTH{1'b0}});
      p_q <= !rf.BUS_in[WIDTH-1] && (rf.BUS_in != {WIDTH{1'b0}});
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (rf.dump_start) begin
          state_d = SEND;
          idx_d   = 3'd0;
          data_d  = capture_value(3'd0, rf.LD_REG, rf.DR, rf.BUS_in, regs_q[0]);
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // dump_valid is 1 throughout SEND, so ready alone marks an accept.
        if (rf.dump_ready) begin
          if (idx_q == 3'd7) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = capture_value(idx_q + 3'd1, rf.LD_REG, rf.DR, rf.BUS_in,
                                   regs_q[idx_q + 3'd1]);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  assign rf.SR1_OUT = (rf.LD_REG && (rf.SR1 == rf.DR)) ? rf.BUS_in : regs_q[rf.SR1];
  assign rf.SR2_OUT = (rf.LD_REG && (rf.SR2 == rf.DR)) ? rf.BUS_in : regs_q[rf.SR2];
`else
  assign rf.SR1_OUT = regs_q[rf.SR1];
  assign rf.SR2_OUT = regs_q[rf.SR2];
`endif

  assign rf.N          = n_q;
  assign rf.Z          = z_q;
  assign rf.P          = p_q;
  assign rf.dump_valid = (state_q == SEND);
  assign rf.dump_busy  = (state_q == SEND);
  assign rf.dump_idx   = idx_q;
  assign rf.dump_data  = data_q;
endmodule

// File: tb/tb_lc3_reg_file.sv
// Randomised scoreboard bench for lc3_reg_file; expectations come from an array/queue model.
module tb_lc3_reg_file;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_reg_file_if #(.WIDTH(W)) rf();
  lc3_reg_file #(.WIDTH(W)) dut (.Clk(clk), .Reset(rst), .rf(rf));

  typedef struct {
    logic [W-1:0] sr1;
    logic [W-1:0] sr2;
    logic [2:0]   nzp;
    logic         valid;
  } rd_exp_t;

  typedef struct {
    logic [2:0]   idx;
    logic [W-1:0] data;
  } dump_exp_t;

  rd_exp_t   rd_q[$];
  dump_exp_t dump_q[$];
  int        checks   = 0;
  int        failures = 0;

  logic [W-1:0] m_regs [8];
  logic [2:0]   m_nzp;
  bit           m_busy;
  int           m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp  = 3'b010;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  task automatic push_word(input int idx);
    dump_exp_t d;
    d.idx  = idx[2:0];
    d.data = m_regs[idx];
    dump_q.push_back(d);
  endtask

  // One clock cycle: drive inputs, queue what the read side should show, advance the model.
  task automatic cyc(input bit ld, input logic [2:0] dr, input logic [2:0] sr1,
                     input logic [2:0] sr2, input logic [W-1:0] bus, input bit ldcc,
                     input bit start, input bit ready);
    rd_exp_t e;
    rf.LD_REG = ld; rf.DR = dr; rf.SR1 = sr1; rf.SR2 = sr2; rf.BUS_in = bus;
    rf.LD_CC = ldcc; rf.dump_start = start; rf.dump_ready = ready;
    e.sr1 = m_regs[sr1];
    e.sr2 = m_regs[sr2];
`ifdef REGFILE_BYPASS_EN
    if (ld && sr1 == dr) e.sr1 = bus;
    if (ld && sr2 == dr) e.sr2 = bus;
`endif
    e.nzp   = m_nzp;
    e.valid = m_busy;
    rd_q.push_back(e);
    if (ld) m_regs[dr] = bus;
    if (ldcc) m_nzp = bus[W-1] ? 3'b100 : ((bus == 16'h0000) ? 3'b010 : 3'b001);
    if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_idx  = 0;
        push_word(0);
      end
    end else if (ready) begin
      if (m_idx == 7) begin
        m_busy = 1'b0;
      end else begin
        m_idx++;
        push_word(m_idx);
      end
    end
    @(posedge clk);
    #1;
  endtask

  rd_exp_t      mon_e;
  dump_exp_t    mon_d;
  logic [W-1:0] held;
  bit           holding = 1'b0;

  // Monitor: compares read ports every cycle and each accepted dump word against the queues.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rd_q.size() > 0) begin
        mon_e = rd_q.pop_front();
        check("sr1_out", rf.SR1_OUT, mon_e.sr1);
        check("sr2_out", rf.SR2_OUT, mon_e.sr2);
        check("nzp", {rf.N, rf.Z, rf.P}, mon_e.nzp);
        check("dump_valid", rf.dump_valid, mon_e.valid);
        check("dump_busy", rf.dump_busy, mon_e.valid);
      end
      if (rf.dump_valid) begin
        if (holding) check("dump_hold", rf.dump_data, held);
        if (rf.dump_ready) begin
          holding = 1'b0;
          if (dump_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dump_extra actual=idx%0d expected=no word", rf.dump_idx);
          end else begin
            mon_d = dump_q.pop_front();
            check("dump_idx", rf.dump_idx, mon_d.idx);
            check("dump_data", rf.dump_data, mon_d.data);
          end
        end else begin
          holding = 1'b1;
          held    = rf.dump_data;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    rf.LD_REG = 1'b0; rf.DR = 3'd0; rf.SR1 = 3'd0; rf.SR2 = 3'd0; rf.BUS_in = 16'h0000;
    rf.LD_CC = 1'b0; rf.dump_start = 1'b0; rf.dump_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_sr1", rf.SR1_OUT, 16'h0000);
    check("rst_nzp", {rf.N, rf.Z, rf.P}, 3'b010);
    check("rst_valid", rf.dump_valid, 1'b0);
    check("rst_idx", rf.dump_idx, 3'd0);
    check("rst_data", rf.dump_data, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass on R4 while it still holds 0, then look again after the edge.
    cyc(1'b1, 3'd4, 3'd0, 3'd4, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Write/read including both ports on one register.
    cyc(1'b1, 3'd3, 3'd0, 3'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 3'd0, 3'd0, 16'h0012, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd3, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd3, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Condition codes: negative, zero, positive, then held with LD_CC low.
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h8000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Dump with alternating ready and dump_start held for the whole of SEND.
    for (int n = 0; n < 8; n++)
      cyc(1'b1, n[2:0], 3'd0, 3'd0, 16'h1000 + n[15:0], 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k > 0 && !m_busy) break;
      cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, k[0]);
    end
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Write to R3 on the edge that accepts word 2.
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (!m_busy) break;
      if (m_idx == 2) cyc(1'b1, 3'd3, 3'd0, 3'd0, 16'h7777, 1'b0, 1'b0, 1'b1);
      else            cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    end

    // Reset in the middle of a dump after three accepts.
    cyc(1'b0, 3'd0, 3'd3, 3'd5, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 3'd3, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b1);
    rf.dump_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_sr1", rf.SR1_OUT, 16'h0000);
    check("mid_rst_sr2", rf.SR2_OUT, 16'h0000);
    check("mid_rst_nzp", {rf.N, rf.Z, rf.P}, 3'b010);
    check("mid_rst_valid", rf.dump_valid, 1'b0);
    check("mid_rst_idx", rf.dump_idx, 3'd0);
    check("mid_rst_data", rf.dump_data, 16'h0000);
    model_reset();
    dump_q.delete();
    rd_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic mixing writes, CC loads, dumps and backpressure.
    for (int k = 0; k < 400; k++) begin
      logic [W-1:0] b;
      b = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
      cyc($urandom_range(0, 1) == 1, 3'($urandom), 3'($urandom), 3'($urandom), b,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    for (int k = 0; k < 20; k++) begin
      if (!m_busy) break;
      cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("dump_words_left", dump_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3_reg_file.md
# lc3_reg_file

LC-3 general-purpose register file: eight 16-bit registers R0–R7, one write port from the datapath bus and two combinational read ports.
- The SR2 read port feeds the ALU operand-B select; SR1 feeds ALU operand A and the address adders.
- Also holds the NZP condition-code register, updated from the bus value.
- Provides a sequential dump engine that streams R0–R7 over a valid/ready handshake to the board debug/hex-display logic.

## Interface
Parameters:
- WIDTH, 16, data width of each register and of the bus (sign bit is WIDTH-1).

Ports (all synchronous to the single clock; reset is the only asynchronous input):
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- LD_REG  in  1  write enable for register array
- DR  in  3  destination register index
- SR1  in  3  read port 1 index
- SR2  in  3  read port 2 index
- BUS_in  in  WIDTH  datapath bus value (write data and CC source)
- LD_CC  in  1  load enable for NZP
- SR1_OUT  out  WIDTH  contents of R[SR1]
- SR2_OUT  out  WIDTH  contents of R[SR2]
- N, Z, P  out  1 each  condition codes
- dump_start  in  1  request a full-register dump
- dump_ready  in  1  consumer accepts current dump word
- dump_valid  out  1  dump word present
- dump_idx  out  3  register index of current dump word
- dump_data  out  WIDTH  captured register value
- dump_busy  out  1  dump in progress

## Operation
- Write: on a rising edge with LD_REG=1, R[DR] <= BUS_in. No write when LD_REG=0.
- Reads: SR1_OUT = R[SR1] and SR2_OUT = R[SR2], purely combinational. Both ports may address the same register.
- Condition codes: on a rising edge with LD_CC=1:
  - N <= BUS_in[WIDTH-1]
  - Z <= (BUS_in == 0)
  - P <= !N && !Z
  - Exactly one of N/Z/P is 1 at all times.
- Dump FSM has two states, IDLE and SEND.
  - IDLE: dump_start=1 → SEND. At the same edge, dump_idx <= 0 and dump_data <= R0.
  - SEND: dump_valid=1 and dump_busy=1.
    - Accept occurs on dump_valid && dump_ready at an edge.
    - On accept with dump_idx<7: dump_idx <= dump_idx+1 and dump_data <= R[dump_idx+1].
    - On accept with dump_idx==7: → IDLE.
    - dump_data is a holding register. It is stable while dump_valid=1 and dump_ready=0, even if the array is written.
  - dump_start is ignored while in SEND.
  - dump_idx wraps only by returning to IDLE; it never counts past 7.
- Capture/write collision: if a dump capture edge and an LD_REG write target the same index, dump_data receives BUS_in (the new value).
- Dump is read-only with respect to the array and CC. Normal writes and reads proceed concurrently.

## Timing
- Reset (asynchronous, any time, including mid-dump):
  - R0–R7 = 0; N=0, Z=1, P=0
  - FSM = IDLE; dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0
- Write-to-read latency: 1 cycle. A value written at edge t appears on SR1_OUT/SR2_OUT after edge t. Same-cycle behaviour is set by the Configuration section.
- CC latency: 1 cycle after the LD_CC edge.
- Dump timing:
  - dump_start sampled at edge t → dump_valid=1 after edge t.
  - With dump_ready held at 1, one word transfers per cycle. A full dump takes 8 cycles, and dump_valid falls after the 8th accept edge.
  - A new dump_start is honoured at the edge after returning to IDLE, never at the 8th accept edge itself.
- No combinational path from dump_ready to dump_valid or dump_data.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When LD_REG=1 and SR1==DR, SR1_OUT = BUS_in in that same cycle.
  - Same rule for SR2/SR2_OUT.
  - The bypass does not affect dump_data (dump_data follows its capture rule in Operation).
- Undefined: read ports always show stored contents; a same-cycle write is visible only after the edge.

## Test plan
- Reset mid-dump: start dump, accept 3 words, assert Reset → dump_valid=0, dump_idx=0, all SRx_OUT=0, NZP=010 immediately (before next edge).
- Write/read: write R3=16'hBEEF and R5=16'h0012, then SR1=3, SR2=5 → SR1_OUT=BEEF, SR2_OUT=0012. Set SR1=SR2=3 → both ports show BEEF.
- CC: LD_CC with BUS_in = 16'h8000, then 0, then 16'h0001 → NZP = 100, 010, 001. With LD_CC=0 and BUS_in changing → NZP unchanged.
- Dump backpressure: preload Rn = 16'h1000+n, start dump, toggle dump_ready every other cycle → words 1000..1007 in order with matching dump_idx. dump_data is stable while ready=0. Done after 8 accepts, with dump_start held high throughout SEND ignored.
- Collision: during SEND with dump_idx=2 and accept pending, write R3=16'h7777 on the accept edge → next word idx=3, data=7777.
- Bypass (macro on/off): LD_REG=1, DR=4, SR2=4, BUS_in=16'hA5A5, old R4=0 → SR2_OUT=A5A5 in that cycle with REGFILE_BYPASS_EN defined, 0000 without it. Both builds show A5A5 after the edge.
